// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request channel between the fetch stage and imem.
// The fetch unit is the master: it raises req with a stable addr, and the
// memory answers with ready plus the instruction word in the same cycle.
interface fetch_pc_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rdata
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// RV32i instruction-fetch stage: owns the PC, issues imem requests,
// fills IF/ID, redirects on taken branches/jumps from EX, squashes the
// wrong path and parks one returned instruction while ID is stalled.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ExeBranch,
  input  logic                   ExeJump,
  input  logic [31:0]            Exe_target,
  input  logic                   stall,
  fetch_pc_unit_if.master        imem,
  output logic [31:0]            IF_ID_pc,
  output logic [31:0]            IF_ID_instr,
  output logic                   IF_ID_valid,
  output logic                   flush_ID_EX
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_DISCARD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        req_c;

  logic        redirect;
  logic [31:0] target;

  // Jumps and taken branches both redirect; targets are word aligned.
  assign redirect = ExeBranch | ExeJump;
  assign target   = {Exe_target[31:2], 2'b00};

  // Outputs are forced to their idle values while reset is asserted, so
  // nothing leaks out before the first reset edge has been seen.
  assign imem.req    = rst_n & req_c;
  assign imem.addr   = rst_n ? pc_q : RESET_PC;
  assign IF_ID_pc    = if_pc_q;
  assign IF_ID_instr = if_instr_q;
  assign IF_ID_valid = rst_n & if_valid_q;
  assign flush_ID_EX = redirect & rst_n;

  // State register and datapath registers; reset abandons any request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      redirect_pc_q <= 32'h0;
      skid_pc_q     <= 32'h0;
      skid_instr_q  <= 32'h0;
      if_pc_q       <= 32'h0;
      if_instr_q    <= NOP_INSTR;
      if_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      if_valid_q    <= if_valid_d;
    end
  end

  // Next-state and request logic; redirect takes priority over stall.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    if_valid_d    = if_valid_q;
    req_c         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        req_c = 1'b1;
        if (redirect) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          if (imem.ready) begin
            pc_d = target;
          end else begin
            // The address must stay put until the old request completes,
            // so the target waits in redirect_pc.
            redirect_pc_d = target;
            state_d       = ST_DISCARD;
          end
        end else if (imem.ready) begin
          pc_d = pc_q + 32'd4;
          if (stall) begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem.rdata;
            state_d      = ST_HOLD;
          end else begin
            if_pc_d    = pc_q;
            if_instr_d = imem.rdata;
            if_valid_d = 1'b1;
          end
        end else if (!stall) begin
          if_valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          pc_d       = target;
          state_d    = ST_FETCH;
        end else if (!stall) begin
          if_pc_d    = skid_pc_q;
          if_instr_d = skid_instr_q;
          if_valid_d = 1'b1;
          state_d    = ST_FETCH;
        end
      end

      ST_DISCARD: begin
        req_c      = 1'b1;
        if_valid_d = 1'b0;
        if_instr_d = NOP_INSTR;
        if (redirect) begin
          redirect_pc_d = target;
        end
        if (imem.ready) begin
          pc_d    = redirect ? target : redirect_pc_q;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios for reset release, redirect,
// redirect during a memory wait, stall/skid, PC wrap and reset during a
// discard, followed by a randomized run against a queue-based model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        ExeBranch;
  logic        ExeJump;
  logic [31:0] Exe_target;
  logic        stall;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid;
  logic        flush_ID_EX;

  int total;
  int bad;

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ExeBranch   (ExeBranch),
    .ExeJump     (ExeJump),
    .Exe_target  (Exe_target),
    .stall       (stall),
    .imem        (bus),
    .IF_ID_pc    (IF_ID_pc),
    .IF_ID_instr (IF_ID_instr),
    .IF_ID_valid (IF_ID_valid),
    .flush_ID_EX (flush_ID_EX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word returned for an address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive inputs just after the edge, answer the memory
  // from the current address, and return at the sampling point.
  task automatic cyc(input logic rn, input logic br, input logic jp,
                     input logic [31:0] tgt, input logic st, input logic rdy);
    @(posedge clk);
    #1;
    rst_n      = rn;
    ExeBranch  = br;
    ExeJump    = jp;
    Exe_target = tgt;
    stall      = st;
    bus.ready  = rdy;
    #1;
    bus.rdata  = word(bus.addr);
    #2;
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b1, 1'b1, 32'h55, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 32'h55, 1'b0, 1'b1);
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus.req); end
    total++; if (bus.addr !== RESET_PC) begin bad++; $display("FAIL rst_addr got=%h exp=%h", bus.addr, RESET_PC); end
    total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", IF_ID_valid); end
    total++; if (flush_ID_EX !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b exp=0", flush_ID_EX); end
    total++; if (IF_ID_pc !== 32'h0) begin bad++; $display("FAIL rst_ifpc got=%h exp=0", IF_ID_pc); end
    total++; if (IF_ID_instr !== NOP_INSTR) begin bad++; $display("FAIL rst_instr got=%h exp=%h", IF_ID_instr, NOP_INSTR); end
  endtask

  task automatic test_sequential();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL seq_idle_req got=%b exp=0", bus.req); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL seq_req got=%b exp=1", bus.req); end
    total++; if (bus.addr !== 32'h0) begin bad++; $display("FAIL seq_addr0 got=%h exp=0", bus.addr); end
    total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL seq_valid0 got=%b exp=0", IF_ID_valid); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (bus.addr !== 32'h4) begin bad++; $display("FAIL seq_addr4 got=%h exp=4", bus.addr); end
    total++; if (IF_ID_pc !== 32'h0 || IF_ID_valid !== 1'b1) begin bad++; $display("FAIL seq_if0 got=%h/%b exp=0/1", IF_ID_pc, IF_ID_valid); end
    total++; if (IF_ID_instr !== word(32'h0)) begin bad++; $display("FAIL seq_instr0 got=%h exp=%h", IF_ID_instr, word(32'h0)); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (bus.addr !== 32'h8) begin bad++; $display("FAIL seq_addr8 got=%h exp=8", bus.addr); end
    total++; if (IF_ID_pc !== 32'h4) begin bad++; $display("FAIL seq_if4 got=%h exp=4", IF_ID_pc); end
  endtask

  task automatic test_redirect();
    cyc(1'b1, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b1);
    total++; if (flush_ID_EX !== 1'b1) begin bad++; $display("FAIL br_flush got=%b exp=1", flush_ID_EX); end
    total++; if (IF_ID_pc !== 32'h8 || IF_ID_valid !== 1'b1) begin bad++; $display("FAIL br_if8 got=%h/%b exp=8/1", IF_ID_pc, IF_ID_valid); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL br_squash_valid got=%b exp=0", IF_ID_valid); end
    total++; if (IF_ID_instr !== NOP_INSTR) begin bad++; $display("FAIL br_squash_instr got=%h exp=%h", IF_ID_instr, NOP_INSTR); end
    total++; if (bus.addr !== 32'h100 || bus.req !== 1'b1) begin bad++; $display("FAIL br_target_req got=%h/%b exp=100/1", bus.addr, bus.req); end
    total++; if (flush_ID_EX !== 1'b0) begin bad++; $display("FAIL br_flush_clear got=%b exp=0", flush_ID_EX); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (IF_ID_pc !== 32'h100 || IF_ID_valid !== 1'b1) begin bad++; $display("FAIL br_if100 got=%h/%b exp=100/1", IF_ID_pc, IF_ID_valid); end
    total++; if (bus.addr !== 32'h104) begin bad++; $display("FAIL br_addr104 got=%h exp=104", bus.addr); end
  endtask

  task automatic test_wait_redirect();
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0203, 1'b0, 1'b0);
    total++; if (bus.addr !== 32'h10) begin bad++; $display("FAIL wr_addr_first got=%h exp=10", bus.addr); end
    total++; if (flush_ID_EX !== 1'b1) begin bad++; $display("FAIL wr_flush got=%b exp=1", flush_ID_EX); end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      total++; if (bus.addr !== 32'h10 || bus.req !== 1'b1) begin bad++; $display("FAIL wr_hold_addr got=%h/%b exp=10/1", bus.addr, bus.req); end
      total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL wr_hold_valid got=%b exp=0", IF_ID_valid); end
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (bus.addr !== 32'h10) begin bad++; $display("FAIL wr_addr_ready got=%h exp=10", bus.addr); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (bus.addr !== 32'h200 || bus.req !== 1'b1) begin bad++; $display("FAIL wr_target got=%h/%b exp=200/1", bus.addr, bus.req); end
    total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL wr_dropped_valid got=%b exp=0", IF_ID_valid); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (IF_ID_pc !== 32'h200 || IF_ID_valid !== 1'b1) begin bad++; $display("FAIL wr_if200 got=%h/%b exp=200/1", IF_ID_pc, IF_ID_valid); end
    total++; if (IF_ID_instr !== word(32'h200)) begin bad++; $display("FAIL wr_instr got=%h exp=%h", IF_ID_instr, word(32'h200)); end
  endtask

  task automatic test_stall();
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_001C, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (bus.addr !== 32'h1C) begin bad++; $display("FAIL st_addr1c got=%h exp=1c", bus.addr); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    total++; if (bus.addr !== 32'h20) begin bad++; $display("FAIL st_addr20 got=%h exp=20", bus.addr); end
    total++; if (IF_ID_pc !== 32'h1C || IF_ID_valid !== 1'b1) begin bad++; $display("FAIL st_if1c got=%h/%b exp=1c/1", IF_ID_pc, IF_ID_valid); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0, (i < 2) ? 1'b1 : 1'b0, 1'b1);
      total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL st_hold_req got=%b exp=0", bus.req); end
      total++; if (IF_ID_pc !== 32'h1C || IF_ID_valid !== 1'b1) begin bad++; $display("FAIL st_hold_if got=%h/%b exp=1c/1", IF_ID_pc, IF_ID_valid); end
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (bus.req !== 1'b1 || bus.addr !== 32'h24) begin bad++; $display("FAIL st_resume got=%h/%b exp=24/1", bus.addr, bus.req); end
    total++; if (IF_ID_pc !== 32'h20 || IF_ID_instr !== word(32'h20)) begin bad++; $display("FAIL st_skid got=%h/%h exp=20/%h", IF_ID_pc, IF_ID_instr, word(32'h20)); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (IF_ID_pc !== 32'h24 || IF_ID_valid !== 1'b1) begin bad++; $display("FAIL st_if24 got=%h/%b exp=24/1", IF_ID_pc, IF_ID_valid); end
  endtask

  task automatic test_wrap();
    cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (bus.addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%h exp=fffffffc", bus.addr); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (bus.addr !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%h exp=0", bus.addr); end
    total++; if (IF_ID_pc !== 32'hFFFF_FFFC || IF_ID_valid !== 1'b1) begin bad++; $display("FAIL wrap_if got=%h/%b exp=fffffffc/1", IF_ID_pc, IF_ID_valid); end
  endtask

  task automatic test_reset_discard();
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 32'h0000_0080, 1'b0, 1'b0);
    total++; if (bus.addr !== 32'h40) begin bad++; $display("FAIL rd_addr40 got=%h exp=40", bus.addr); end
    cyc(1'b0, 1'b1, 1'b0, 32'h0000_0099, 1'b0, 1'b0);
    total++; if (bus.req !== 1'b0 || flush_ID_EX !== 1'b0) begin bad++; $display("FAIL rd_in_reset got=%b/%b exp=0/0", bus.req, flush_ID_EX); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (bus.req !== 1'b0 || IF_ID_valid !== 1'b0) begin bad++; $display("FAIL rd_after got=%b/%b exp=0/0", bus.req, IF_ID_valid); end
    total++; if (bus.addr !== RESET_PC) begin bad++; $display("FAIL rd_addr got=%h exp=%h", bus.addr, RESET_PC); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (bus.req !== 1'b1 || bus.addr !== RESET_PC) begin bad++; $display("FAIL rd_lost got=%h/%b exp=%h/1", bus.addr, bus.req, RESET_PC); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (IF_ID_pc !== RESET_PC || IF_ID_valid !== 1'b1) begin bad++; $display("FAIL rd_first got=%h/%b exp=%h/1", IF_ID_pc, IF_ID_valid, RESET_PC); end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Randomized run: the model tracks the fetch unit as "started", a PC,
  // the IF/ID contents, a parked-instruction queue and a pending-target
  // queue, and is stepped once per clock with the same inputs.
  task automatic test_random();
    logic        m_started;
    logic [31:0] m_pc, m_if_pc, m_if_instr, t;
    logic        m_if_valid;
    ent_t        m_skid[$];
    logic [31:0] m_pend[$];
    logic        rn, br, jp, st, rdy, redir;
    logic [31:0] tgt;
    logic        e_req, e_valid, e_flush;
    logic [31:0] e_addr;
    ent_t        e;
    m_started = 1'b0; m_pc = RESET_PC; m_if_pc = 32'h0;
    m_if_instr = NOP_INSTR; m_if_valid = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rn  = (n == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      br  = ($urandom_range(0, 9) == 0);
      jp  = ($urandom_range(0, 15) == 0);
      tgt = $urandom();
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      cyc(rn, br, jp, tgt, st, rdy);
      redir = br | jp;
      t = {tgt[31:2], 2'b00};
      if (!rn) begin
        e_req = 1'b0; e_addr = RESET_PC; e_valid = 1'b0; e_flush = 1'b0;
      end else begin
        e_req = m_started && (m_skid.size() == 0);
        e_addr = m_pc; e_valid = m_if_valid; e_flush = redir;
      end
      total++; if (bus.req !== e_req) begin bad++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", n, bus.req, e_req); end
      total++; if (bus.addr !== e_addr) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", n, bus.addr, e_addr); end
      total++; if (IF_ID_valid !== e_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, IF_ID_valid, e_valid); end
      total++; if (flush_ID_EX !== e_flush) begin bad++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", n, flush_ID_EX, e_flush); end
      if (n > 0) begin
        total++; if (IF_ID_pc !== m_if_pc) begin bad++; $display("FAIL rnd_ifpc cyc=%0d got=%h exp=%h", n, IF_ID_pc, m_if_pc); end
        total++; if (IF_ID_instr !== m_if_instr) begin bad++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", n, IF_ID_instr, m_if_instr); end
      end
      // advance the model across the coming edge
      if (!rn) begin
        m_started = 1'b0; m_pc = RESET_PC; m_if_pc = 32'h0;
        m_if_instr = NOP_INSTR; m_if_valid = 1'b0;
        m_skid.delete(); m_pend.delete();
      end else if (!m_started) begin
        m_started = 1'b1;
      end else if (m_skid.size() > 0) begin
        if (redir) begin
          m_skid.delete(); m_if_valid = 1'b0; m_if_instr = NOP_INSTR; m_pc = t;
        end else if (!st) begin
          e = m_skid.pop_front();
          m_if_pc = e.pc; m_if_instr = e.instr; m_if_valid = 1'b1;
        end
      end else if (m_pend.size() > 0) begin
        m_if_valid = 1'b0; m_if_instr = NOP_INSTR;
        if (redir) m_pend[0] = t;
        if (rdy) m_pc = m_pend.pop_front();
      end else if (redir) begin
        m_if_valid = 1'b0; m_if_instr = NOP_INSTR;
        if (rdy) m_pc = t;
        else m_pend.push_back(t);
      end else if (rdy) begin
        if (st) begin
          e.pc = m_pc; e.instr = word(m_pc);
          m_skid.push_back(e);
        end else begin
          m_if_pc = m_pc; m_if_instr = word(m_pc); m_if_valid = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end else if (!st) begin
        m_if_valid = 1'b0;
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    ExeBranch = 1'b0;
    ExeJump = 1'b0;
    Exe_target = 32'h0;
    stall = 1'b0;
    bus.ready = 1'b0;
    bus.rdata = 32'h0;
    test_reset();
    test_sequential();
    test_redirect();
    test_wait_redirect();
    test_stall();
    test_wrap();
    test_reset_discard();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
